// File: rtl/mem_access_unit_if.sv
// Pipeline-side and data-memory-side signals of the load/store unit.
// No logic; the slave modport is the unit and the master modport is its environment.
// The memory side has no backpressure beyond dmem_ack.
interface mem_access_unit_if;
  // pipeline side
  logic        start;
  logic        mem_w;
  logic [1:0]  B_H_W;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        timeout;
  // data memory side
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport slave (
    input  start, mem_w, B_H_W, sign, addr, wdata,
    output busy, done, rdata, misalign, timeout,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport master (
    output start, mem_w, B_H_W, sign, addr, wdata,
    input  busy, done, rdata, misalign, timeout,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: byte/half/word lane steering, load extension, misalign and ack-timeout handling.
// Latency: start at T, ack at T+1 -> done at T+2; misaligned ops finish at T+1 with no memory request.
// Backpressure: busy stalls the pipeline while a request is outstanding; start outside IDLE is dropped.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst_n,
  mem_access_unit_if.slave bus
);

  // wide enough to hold TIMEOUT itself
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // transition qualifiers from the next-state logic
  logic accept;    // aligned start taken in IDLE
  logic reject;    // misaligned start taken in IDLE
  logic ack_hit;   // ack sampled while requesting
  logic tmo_hit;   // last allowed wait cycle passed without ack

  // wait counter for the outstanding request
  logic [CW-1:0] wait_cnt;

  // attributes of the op in flight, needed again when the ack returns
  logic [1:0] size_q;
  logic       sign_q;
  logic [1:0] off_q;

  // registered outputs
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        mis_q;
  logic        tmo_q;

  // lane decode of the incoming op and extraction of the returning word
  logic        misaligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_c;

  // Decode size into byte enables, replicated store data and the alignment check.
  always_comb begin
    be_c       = 4'b1111;
    wdata_c    = bus.wdata;
    misaligned = (bus.addr[1:0] != 2'b00);
    unique case (bus.B_H_W)
      2'b01: begin
        be_c       = 4'b0001 << bus.addr[1:0];
        wdata_c    = {4{bus.wdata[7:0]}};
        misaligned = 1'b0;
      end
      2'b10: begin
        be_c       = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{bus.wdata[15:0]}};
        misaligned = bus.addr[0];
      end
      default: begin
        // 00 and 11 are both full words; defaults above already describe them
      end
    endcase
  end

  // Pick the addressed byte/half out of the read word and sign- or zero-extend it.
  always_comb begin
    ld_byte = bus.dmem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    load_c  = bus.dmem_rdata;
    unique case (size_q)
      2'b01:   load_c = {{24{sign_q & ld_byte[7]}}, ld_byte};
      2'b10:   load_c = {{16{sign_q & ld_half[15]}}, ld_half};
      default: load_c = bus.dmem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack on the final wait cycle still wins over the timeout.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    ack_hit = 1'b0;
    tmo_hit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (misaligned) begin
            reject  = 1'b1;
            state_d = S_ERR;
          end else begin
            accept  = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.dmem_ack) begin
          ack_hit = 1'b1;
          state_d = S_DONE;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Count REQ cycles that pass without an ack; restarts with every accepted op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if ((state_q == S_REQ) && !bus.dmem_ack) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Launch and retire the memory request, capture load data, and raise the completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      off_q   <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      // DONE and ERR each last one cycle, so these are single-cycle pulses
      done_q <= (state_d == S_DONE) || (state_d == S_ERR);
      mis_q  <= reject;
      tmo_q  <= tmo_hit;

      if (accept) begin
        req_q   <= 1'b1;
        we_q    <= bus.mem_w;
        addr_q  <= {bus.addr[31:2], 2'b00};
        be_q    <= be_c;
        wdata_q <= wdata_c;
        size_q  <= bus.B_H_W;
        sign_q  <= bus.sign;
        off_q   <= bus.addr[1:0];
      end

      // stores leave rdata untouched; we_q still holds this op's direction here
      if (ack_hit && !we_q) begin
        rdata_q <= load_c;
      end

      // address/lanes/data are left as they were; only the strobes drop
      if (ack_hit || tmo_hit) begin
        req_q <= 1'b0;
        we_q  <= 1'b0;
      end
    end
  end

  // busy must reach the pipeline in the same cycle as start, hence combinational
  assign bus.busy       = ((state_q == S_IDLE) && bus.start) || (state_q == S_REQ);
  assign bus.done       = done_q;
  assign bus.misalign   = mis_q;
  assign bus.timeout    = tmo_q;
  assign bus.rdata      = rdata_q;
  assign bus.dmem_req   = req_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_be    = be_q;
  assign bus.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected requests/responses,
// a negedge monitor pops and compares whenever dmem_req rises/falls or done pulses.
// Reference model works on byte counts and shifts rather than lane decode tables.
module tb_mem_access_unit;

  localparam int TMO = 255;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          len;
    int          rise_cyc;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        tmo;
    int          done_cyc;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [31:0] model_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural reference: sizes as byte counts, lanes as shifted masks.
  function automatic void model(input logic [1:0] bhw, input logic sg, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output logic mis, output logic [3:0] be,
                                output logic [31:0] wrep, output logic [31:0] ld);
    int off, nb;
    logic [31:0] mask, v;
    off  = int'(a % 4);
    nb   = (bhw == 2'b01) ? 1 : (bhw == 2'b10) ? 2 : 4;
    mis  = (a % nb) != 0;
    be   = 4'(((1 << nb) - 1) << off);
    if (nb == 1)      wrep = {24'd0, wd[7:0]} * 32'h0101_0101;
    else if (nb == 2) wrep = {16'd0, wd[15:0]} * 32'h0001_0001;
    else              wrep = wd;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v    = (rd >> (8 * off)) & mask;
    if (sg && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
    ld   = v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  req_t cur_req;
  rsp_t cur_rsp;
  logic req_prev = 1'b0;
  int   req_len  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev = 1'b0;
      req_len  = 0;
    end else begin
      if (bus.dmem_req) begin
        if (!req_prev) begin
          chk("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
          if (exp_req_q.size() != 0) begin
            cur_req = exp_req_q.pop_front();
            chk("req_rise_cycle", 32'(cyc), 32'(cur_req.rise_cyc));
            chk("dmem_addr", bus.dmem_addr, cur_req.addr);
            chk("dmem_be", 32'(bus.dmem_be), 32'(cur_req.be));
            chk("dmem_we", 32'(bus.dmem_we), 32'(cur_req.we));
            chk("dmem_wdata", bus.dmem_wdata, cur_req.wdata);
          end
          req_len = 0;
        end else begin
          chk("req_stable", 32'({bus.dmem_addr, bus.dmem_be, bus.dmem_we, bus.dmem_wdata} ===
                                {cur_req.addr, cur_req.be, cur_req.we, cur_req.wdata}), 32'd1);
        end
        req_len++;
      end else if (req_prev) begin
        chk("req_len", 32'(req_len), 32'(cur_req.len));
      end
      req_prev = bus.dmem_req;

      if (bus.done) begin
        chk("done_expected", 32'(exp_rsp_q.size() != 0), 32'd1);
        if (exp_rsp_q.size() != 0) begin
          cur_rsp = exp_rsp_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(cur_rsp.done_cyc));
          chk("rdata", bus.rdata, cur_rsp.rdata);
          chk("misalign", 32'(bus.misalign), 32'(cur_rsp.mis));
          chk("timeout", 32'(bus.timeout), 32'(cur_rsp.tmo));
        end
      end else if (bus.misalign || bus.timeout) begin
        chk("flag_without_done", 32'({bus.misalign, bus.timeout}), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_junk();
    bus.start = 1'($urandom_range(0, 1));
    bus.mem_w = 1'($urandom_range(0, 1));
    bus.B_H_W = 2'($urandom_range(0, 3));
    bus.sign  = 1'($urandom_range(0, 1));
    bus.addr  = $urandom;
    bus.wdata = $urandom;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req"},   32'(bus.dmem_req), 32'd0);
    chk({tag, "_we"},    32'(bus.dmem_we), 32'd0);
    chk({tag, "_addr"},  bus.dmem_addr, 32'd0);
    chk({tag, "_be"},    32'(bus.dmem_be), 32'd0);
    chk({tag, "_wdata"}, bus.dmem_wdata, 32'd0);
    chk({tag, "_rdata"}, bus.rdata, 32'd0);
    chk({tag, "_done"},  32'(bus.done), 32'd0);
    chk({tag, "_mis"},   32'(bus.misalign), 32'd0);
    chk({tag, "_tmo"},   32'(bus.timeout), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
  endtask

  // One op: d = REQ cycles without ack before the ack; d >= TMO means never ack.
  task automatic do_op(input logic mw, input logic [1:0] bhw, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input int d, input bit junk);
    logic mis;
    logic [3:0] be;
    logic [31:0] wrep, ld;
    bit tmo;
    int s;
    req_t rq;
    rsp_t rs;
    model(bhw, sg, a, wd, rd, mis, be, wrep, ld);
    tmo = (d >= TMO) && !mis;

    @(posedge clk); #1;
    bus.start = 1'b1; bus.mem_w = mw; bus.B_H_W = bhw; bus.sign = sg;
    bus.addr = a; bus.wdata = wd;
    bus.dmem_ack = 1'($urandom_range(0, 1));
    bus.dmem_rdata = $urandom;
    s = cyc;
    if (!mis) begin
      rq.addr = a & 32'hFFFF_FFFC; rq.be = be; rq.we = mw; rq.wdata = wrep;
      rq.len = tmo ? TMO : d + 1;
      rq.rise_cyc = s + 1;
      exp_req_q.push_back(rq);
    end
    rs.mis = mis;
    rs.tmo = tmo;
    rs.rdata = (!mis && !tmo && !mw) ? ld : model_rdata;
    rs.done_cyc = s + (mis ? 1 : tmo ? TMO + 1 : d + 2);
    model_rdata = rs.rdata;
    exp_rsp_q.push_back(rs);
    #1 chk("busy_start", 32'(bus.busy), 32'd1);

    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.dmem_ack = 1'b0;
    if (!mis) begin
      for (int k = 0; k < (tmo ? TMO : d); k++) begin
        if (junk) drive_junk();
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = $urandom;
        #1 chk("busy_req", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
      end
      if (!tmo) begin
        if (junk) drive_junk();
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = rd;
        #1 chk("busy_ack", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
      end
    end
    bus.start = 1'b0;
    bus.dmem_ack = 1'($urandom_range(0, 1));
    bus.dmem_rdata = $urandom;
    #1 chk("busy_end", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    bus.dmem_ack = 1'($urandom_range(0, 1));
    #1 chk("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    req_t rq;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.mem_w = 1'b0; bus.B_H_W = 2'b00; bus.sign = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    #12;
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // LB signed, top byte lane
    do_op(1'b0, 2'b01, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 1'b0);
    chk("lb_rdata_const", bus.rdata, 32'hFFFF_FF80);
    // LHU upper half
    do_op(1'b0, 2'b10, 1'b0, 32'h0000_0202, 32'h0, 32'hBEEF_0000, 0, 1'b0);
    chk("lhu_rdata_const", bus.rdata, 32'h0000_BEEF);
    // SB lane 1; rdata keeps the LHU result
    do_op(1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h1234_56AB, 32'h0, 0, 1'b0);
    chk("sb_keeps_rdata", bus.rdata, 32'h0000_BEEF);
    // SW misaligned: no request at all
    do_op(1'b1, 2'b00, 1'b0, 32'h0000_0006, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    // LW with no ack ever
    do_op(1'b0, 2'b00, 1'b0, 32'h0000_0040, 32'h0, 32'h0, TMO, 1'b0);
    // LW, ack after 5 wait cycles, stray starts during the wait
    do_op(1'b0, 2'b11, 1'b0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 5, 1'b1);
    chk("lw_delayed_rdata", bus.rdata, 32'hCAFE_F00D);

    // reset in the middle of an outstanding LW
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mem_w = 1'b0; bus.B_H_W = 2'b00; bus.sign = 1'b0;
    bus.addr = 32'h0000_0080; bus.dmem_ack = 1'b0;
    rq.addr = 32'h0000_0080; rq.be = 4'hF; rq.we = 1'b0; rq.wdata = bus.wdata;
    rq.len = 0; rq.rise_cyc = cyc + 1;
    exp_req_q.push_back(rq);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1 chk_outputs_zero("midreq_reset");
    model_rdata = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("no_done_after_reset", 32'(bus.done), 32'd0);
    do_op(1'b0, 2'b01, 1'b0, 32'h0000_0082, 32'h0, 32'h0055_0000, 1, 1'b0);

    // randomized ops
    for (int i = 0; i < 60; i++) begin
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, $urandom, int'($urandom_range(0, 6)), bit'($urandom_range(0, 1)));
    end

    bus.dmem_ack = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("exp_req_drained", 32'(exp_req_q.size()), 32'd0);
    chk("exp_rsp_drained", 32'(exp_rsp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
